// File: rtl/ev22_pkg.sv
// Shared EV22 core definitions: IF/ID datapath widths, kill encoding,
// IF/ID sequencing state encodings and the per-cycle datapath action.
package ev22_pkg;

  localparam int unsigned IW_DEF  = 16;
  localparam int unsigned AW_DEF  = 10;
  localparam logic [15:0] NOP_DEF = 16'h0;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_STALL   = 2'd1,
    ST_FLUSHED = 2'd2
  } ifid_state_t;

  typedef enum logic [1:0] {
    ACT_LOAD = 2'd0,
    ACT_HOLD = 2'd1,
    ACT_KILL = 2'd2
  } ifid_act_t;

endpackage

// File: rtl/uc2_stall_wdog.sv
// Stall watchdog: counts consecutive stall cycles (saturating at MAX_STALL)
// and raises a sticky timeout once the count reaches the limit.
module uc2_stall_wdog #(
  parameter int unsigned MAX_STALL = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] stall_cnt,
  output logic       stall_timeout
);

  localparam logic [7:0] LIMIT = 8'(MAX_STALL);

  logic [7:0] r_cnt;
  logic       r_timeout;
  logic [7:0] w_cnt_nxt;

  // Next count: clear wins, otherwise saturating increment while stalled.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (clr) begin
      w_cnt_nxt = '0;
    end else if (inc && (r_cnt != LIMIT)) begin
      w_cnt_nxt = r_cnt + 8'd1;
    end
  end

  // Counter and sticky timeout; timeout rises on the edge the count hits the limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_timeout <= r_timeout | (w_cnt_nxt == LIMIT);
    end
  end

  assign stall_cnt     = r_cnt;
  assign stall_timeout = r_timeout;

endmodule

// File: rtl/uc2_ifid_stage.sv
// IF/ID pipeline register with stall/flush sequencing and a stall watchdog.
// Priority each cycle: reset > flush > h1 > normal load.
module uc2_ifid_stage
  import ev22_pkg::*;
#(
  parameter int unsigned     IW        = IW_DEF,
  parameter int unsigned     AW        = AW_DEF,
  parameter logic [IW-1:0]   NOP       = IW'(NOP_DEF),
  parameter int unsigned     MAX_STALL = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          h1,
  input  logic          flush,
  input  logic [IW-1:0] if_instr,
  input  logic [AW-1:0] if_pc,
  input  logic          if_valid,
  output logic          pc_we,
  output logic          id_bubble,
  output logic [IW-1:0] id_instr,
  output logic [AW-1:0] id_pc,
  output logic          id_valid,
  output logic [1:0]    state_o,
  output logic [7:0]    stall_cnt,
  output logic          stall_timeout
);

  ifid_state_t   r_state;
  ifid_state_t   w_state_nxt;
  ifid_act_t     w_act;
  logic [IW-1:0] r_instr;
  logic [AW-1:0] r_pc;
  logic          r_valid;
  logic          w_inc;
  logic          w_clr;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: every legal state follows the same flush/h1 rules;
  // the unused encoding recovers to RUN.
  always_comb begin
    w_state_nxt = ST_RUN;
    case (r_state)
      ST_RUN, ST_STALL, ST_FLUSHED: begin
        if (flush) begin
          w_state_nxt = ST_FLUSHED;
        end else if (h1) begin
          w_state_nxt = ST_STALL;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Outputs: PC enable and bubble depend on the inputs only; the datapath
  // action also forces a plain load when recovering from the unused encoding.
  always_comb begin
    pc_we     = flush | ~h1;
    id_bubble = h1 & ~flush;
    w_act     = ACT_LOAD;
    case (r_state)
      ST_RUN, ST_STALL, ST_FLUSHED: begin
        if (flush) begin
          w_act = ACT_KILL;
        end else if (h1) begin
          w_act = ACT_HOLD;
        end else begin
          w_act = ACT_LOAD;
        end
      end
      default: w_act = ACT_LOAD;
    endcase
  end

  // IF/ID register: kill to NOP, hold, or load from fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr <= NOP;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else begin
      case (w_act)
        ACT_KILL: begin
          r_instr <= NOP;
          r_pc    <= if_pc;
          r_valid <= 1'b0;
        end
        ACT_HOLD: begin
          r_instr <= r_instr;
          r_pc    <= r_pc;
          r_valid <= r_valid;
        end
        default: begin
          r_instr <= if_instr;
          r_pc    <= if_pc;
          r_valid <= if_valid;
        end
      endcase
    end
  end

  assign w_inc = (w_act == ACT_HOLD);
  assign w_clr = ~w_inc;

  uc2_stall_wdog #(
    .MAX_STALL(MAX_STALL)
  ) u_wdog (
    .clk          (clk),
    .reset        (reset),
    .inc          (w_inc),
    .clr          (w_clr),
    .stall_cnt    (stall_cnt),
    .stall_timeout(stall_timeout)
  );

  assign id_instr = r_instr;
  assign id_pc    = r_pc;
  assign id_valid = r_valid;
  assign state_o  = r_state;

endmodule

// File: tb/tb_uc2_ifid_stage.sv
// Bench for uc2_ifid_stage: two instances (default limit 15 and limit 4)
// share stimulus and are compared each cycle against a behavioural model.
module tb_uc2_ifid_stage;

  localparam int unsigned IW = 16;
  localparam int unsigned AW = 10;
  localparam logic [IW-1:0] NOPV = 16'h0;

  logic          clk = 1'b0;
  logic          reset;
  logic          h1;
  logic          flush;
  logic [IW-1:0] if_instr;
  logic [AW-1:0] if_pc;
  logic          if_valid;

  logic          pc_we_a, bub_a, val_a, to_a;
  logic [IW-1:0] instr_a;
  logic [AW-1:0] pc_a;
  logic [1:0]    st_a;
  logic [7:0]    cnt_a;

  logic          pc_we_b, bub_b, val_b, to_b;
  logic [IW-1:0] instr_b;
  logic [AW-1:0] pc_b;
  logic [1:0]    st_b;
  logic [7:0]    cnt_b;

  int checks   = 0;
  int failures = 0;

  // Model state
  logic [IW-1:0] m_instr;
  logic [AW-1:0] m_pc;
  logic          m_valid;
  int            m_state;
  int            m_cnt [2];
  bit            m_to  [2];
  int            m_lim [2] = '{15, 4};
  logic [AW-1:0] m_last_pc;

  always #5 clk = ~clk;

  uc2_ifid_stage dut_a (
    .clk(clk), .reset(reset), .h1(h1), .flush(flush),
    .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid),
    .pc_we(pc_we_a), .id_bubble(bub_a), .id_instr(instr_a), .id_pc(pc_a),
    .id_valid(val_a), .state_o(st_a), .stall_cnt(cnt_a), .stall_timeout(to_a)
  );

  uc2_ifid_stage #(.MAX_STALL(4)) dut_b (
    .clk(clk), .reset(reset), .h1(h1), .flush(flush),
    .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid),
    .pc_we(pc_we_b), .id_bubble(bub_b), .id_instr(instr_b), .id_pc(pc_b),
    .id_valid(val_b), .state_o(st_b), .stall_cnt(cnt_b), .stall_timeout(to_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_instr = NOPV;
    m_pc    = '0;
    m_valid = 1'b0;
    m_state = 0;
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0;
      m_to[i]  = 1'b0;
    end
  endtask

  // Behavioural rule for one clock edge with the current inputs.
  task automatic model_edge();
    if (flush) begin
      m_instr = NOPV;
      m_valid = 1'b0;
      m_pc    = if_pc;
      m_state = 2;
      for (int i = 0; i < 2; i++) m_cnt[i] = 0;
    end else if (h1) begin
      m_state = 1;
      for (int i = 0; i < 2; i++) begin
        if (m_cnt[i] < m_lim[i]) m_cnt[i] = m_cnt[i] + 1;
        if (m_cnt[i] == m_lim[i]) m_to[i] = 1'b1;
      end
    end else begin
      m_instr = if_instr;
      m_pc    = if_pc;
      m_valid = if_valid;
      m_state = 0;
      for (int i = 0; i < 2; i++) m_cnt[i] = 0;
    end
  endtask

  task automatic check_regs();
    chk("a_id_instr", 32'(instr_a), 32'(m_instr));
    chk("a_id_pc",    32'(pc_a),    32'(m_pc));
    chk("a_id_valid", 32'(val_a),   32'(m_valid));
    chk("a_state",    32'(st_a),    32'(m_state));
    chk("a_cnt",      32'(cnt_a),   32'(m_cnt[0]));
    chk("a_timeout",  32'(to_a),    32'(m_to[0]));
    chk("b_id_instr", 32'(instr_b), 32'(m_instr));
    chk("b_id_pc",    32'(pc_b),    32'(m_pc));
    chk("b_id_valid", 32'(val_b),   32'(m_valid));
    chk("b_state",    32'(st_b),    32'(m_state));
    chk("b_cnt",      32'(cnt_b),   32'(m_cnt[1]));
    chk("b_timeout",  32'(to_b),    32'(m_to[1]));
  endtask

  // One cycle: drive inputs, check combinational outputs, clock, check registers.
  task automatic cyc(input logic h, input logic f, input logic v, input logic [AW-1:0] pc);
    h1       = h;
    flush    = f;
    if_valid = v;
    if_pc    = pc;
    if_instr = IW'($urandom);
    #1;
    chk("a_pc_we",     32'(pc_we_a), (f || !h) ? 32'd1 : 32'd0);
    chk("a_id_bubble", 32'(bub_a),   (h && !f) ? 32'd1 : 32'd0);
    chk("b_pc_we",     32'(pc_we_b), (f || !h) ? 32'd1 : 32'd0);
    chk("b_id_bubble", 32'(bub_b),   (h && !f) ? 32'd1 : 32'd0);
    @(posedge clk);
    model_edge();
    #1;
    check_regs();
  endtask

  // Asynchronous reset pulse away from any clock edge.
  task automatic pulse_reset();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_regs();
    reset = 1'b0;
    @(posedge clk);
    #1;
    model_edge();
    check_regs();
  endtask

  initial begin
    reset    = 1'b1;
    h1       = 1'b0;
    flush    = 1'b0;
    if_valid = 1'b0;
    if_pc    = '0;
    if_instr = '0;
    #1;
    model_reset();
    check_regs();
    @(posedge clk);
    #1;
    check_regs();
    reset = 1'b0;

    // Plain fetch stream A/B/C.
    cyc(1'b0, 1'b0, 1'b1, 10'd5);
    chk("t2_pc5", 32'(pc_a), 32'd5);
    cyc(1'b0, 1'b0, 1'b1, 10'd6);
    chk("t2_pc6", 32'(pc_a), 32'd6);
    cyc(1'b0, 1'b0, 1'b1, 10'd7);
    chk("t2_pc7", 32'(pc_a), 32'd7);

    // Reset mid-run takes effect without a clock edge.
    pulse_reset();

    // B held for 3 stall cycles while C waits in IF.
    cyc(1'b0, 1'b0, 1'b1, 10'd5);
    cyc(1'b0, 1'b0, 1'b1, 10'd6);
    for (int i = 1; i <= 3; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 10'd7);
      chk("t3_hold_pc", 32'(pc_a), 32'd6);
      chk("t3_cnt", 32'(cnt_a), 32'(i));
    end
    cyc(1'b0, 1'b0, 1'b1, 10'd7);
    chk("t3_c_pc", 32'(pc_a), 32'd7);

    // Simultaneous h1 and flush: flush wins.
    cyc(1'b1, 1'b1, 1'b1, 10'd20);
    chk("t4_state", 32'(st_a), 32'd2);
    chk("t4_valid", 32'(val_a), 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 10'd40);
    chk("t4_reload", 32'(st_a), 32'd0);

    // Long stall: limit-4 instance times out on the 4th edge and saturates.
    for (int i = 1; i <= 6; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 10'd41);
      chk("t5_to_b", 32'(to_b), (i >= 4) ? 32'd1 : 32'd0);
    end
    chk("t5_cnt_b", 32'(cnt_b), 32'd4);
    cyc(1'b0, 1'b0, 1'b1, 10'd41);
    cyc(1'b0, 1'b0, 1'b1, 10'd42);
    chk("t5_sticky", 32'(to_b), 32'd1);

    // Back-to-back flushes, then a normal load.
    cyc(1'b0, 1'b1, 1'b1, 10'd100);
    cyc(1'b0, 1'b1, 1'b1, 10'd200);
    chk("t6_state", 32'(st_a), 32'd2);
    cyc(1'b0, 1'b0, 1'b1, 10'd300);
    chk("t6_load", 32'(pc_a), 32'd300);

    // Default-limit instance saturates at 15 over a 17-cycle stall.
    for (int i = 0; i < 17; i++) cyc(1'b1, 1'b0, 1'b1, 10'd301);
    chk("sat15_cnt", 32'(cnt_a), 32'd15);
    chk("sat15_to",  32'(to_a),  32'd1);

    // Reset mid-stall clears timeouts and abandons the held instruction.
    pulse_reset();
    chk("rst_to_a", 32'(to_a), 32'd0);

    // Randomised traffic.
    m_last_pc = '0;
    for (int i = 0; i < 300; i++) begin
      logic rh, rf, rv;
      rh = ($urandom_range(0, 99) < 35);
      rf = ($urandom_range(0, 99) < 10);
      rv = ($urandom_range(0, 99) < 85);
      if (!rh || rf) m_last_pc = m_last_pc + 10'd1;
      cyc(rh, rf, rv, m_last_pc);
      if (i == 150) pulse_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
